// File: rtl/sobel_stream_filter.sv
// -----------------------------------------------------------------------------
// sobel_stream_filter
// Streaming 3x3 Sobel edge detector for raster-order pixels. Two line buffers
// plus a 3x3 window feed a fixed 3-stage pipeline:
//   stage 1: Gx / Gy, stage 2: |Gx|, |Gy|, S = |Gx|+|Gy|, stage 3: mode result.
// One result is produced per interior pixel; border pixels produce nothing.
//
// Ports
//   clk        clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   in_valid   in_pixel / in_sof valid this cycle (no backpressure)
//   in_pixel   input pixel, unsigned PIX_W bits
//   in_sof     marks pixel (0,0) of a frame; latches mode and threshold
//   mode       0 scaled magnitude, 1 threshold, 2 |Gx| only, 3 |Gy| only
//   threshold  unsigned compare level against S for mode 1
//   out_valid  out_pixel valid
//   out_pixel  result pixel
//   out_sof    first interior result of the frame (1,1)
//   out_eof    last interior result of the frame (IMG_H-2, IMG_W-2)
// -----------------------------------------------------------------------------
module sobel_stream_filter #(
   parameter int PIX_W = 8,
   parameter int IMG_W = 640,
   parameter int IMG_H = 480
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [PIX_W-1:0] in_pixel,
   input  logic             in_sof,
   input  logic [1:0]       mode,
   input  logic [PIX_W+2:0] threshold,
   output logic             out_valid,
   output logic [PIX_W-1:0] out_pixel,
   output logic             out_sof,
   output logic             out_eof
);

   localparam int G_W   = PIX_W + 3;
   localparam int COL_W = $clog2(IMG_W);
   localparam int ROW_W = $clog2(IMG_H);

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
   localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
   localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);
   localparam logic [PIX_W-1:0] PIX_MAX  = '1;

   // ---------------------------------------------------------------------------
   // Raster position of the pixel being accepted
   // ---------------------------------------------------------------------------
   logic             accept;
   logic [COL_W-1:0] col_q, col_d, cur_col;
   logic [ROW_W-1:0] row_q, row_d, cur_row;

   always_comb begin
      accept  = in_valid;
      cur_col = in_sof ? '0 : col_q;
      cur_row = in_sof ? '0 : row_q;
      col_d   = col_q;
      row_d   = row_q;
      if (accept) begin
         if (cur_col == COL_LAST) begin
            col_d = '0;
            row_d = (cur_row == ROW_LAST) ? '0 : cur_row + ROW_W'(1);
         end else begin
            col_d = cur_col + COL_W'(1);
            row_d = cur_row;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Line buffers. Buffer 0 holds the previous line, buffer 1 the one before.
   // The registered read is issued one access ahead at col_d, the column of the
   // next pixel to arrive, so its data is ready when that pixel is accepted.
   // Read and write addresses never collide because col_d != cur_col.
   // After an in_sof jump the pre-read address may be wrong, but that data only
   // lands in row 0 and row -1 slots, which never contribute to a result.
   // ---------------------------------------------------------------------------
   logic [1:0][PIX_W-1:0] lb_wdata;
   logic [1:0][PIX_W-1:0] lb_rdata;

   assign lb_wdata = {lb_rdata[0], in_pixel};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_line_buf
         logic [PIX_W-1:0] mem [IMG_W];
         logic [PIX_W-1:0] rd_q;

         always_ff @(posedge clk) begin
            if (accept) begin
               mem[cur_col] <= lb_wdata[gi];
            end
            rd_q <= mem[col_d];
         end

         assign lb_rdata[gi] = rd_q;
      end
   endgenerate

   // ---------------------------------------------------------------------------
   // 3x3 window: win_q[row][col], row 0 = oldest line, col 2 = newest column
   // ---------------------------------------------------------------------------
   logic [2:0][PIX_W-1:0] new_col;
   logic [PIX_W-1:0]      win_q [3][3];

   assign new_col = {in_pixel, lb_rdata[0], lb_rdata[1]};

   always_ff @(posedge clk) begin
      if (accept) begin
         for (int r = 0; r < 3; r++) begin
            win_q[r][0] <= win_q[r][1];
            win_q[r][1] <= win_q[r][2];
            win_q[r][2] <= new_col[r];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Arithmetic
   // ---------------------------------------------------------------------------
   function automatic logic signed [G_W-1:0] ext(input logic [PIX_W-1:0] p);
      return $signed({3'b000, p});
   endfunction

   // Divide by 4 and clamp to the pixel range.
   function automatic logic [PIX_W-1:0] sat_q4(input logic [G_W-1:0] v);
      logic [G_W-1:0] s;
      s = v >> 2;
      if (s > {3'b000, PIX_MAX}) begin
         return PIX_MAX;
      end
      return s[PIX_W-1:0];
   endfunction

   logic signed [G_W-1:0] gx_d, gy_d, gx_q, gy_q;
   logic [G_W-1:0]        ax_d, ay_d, ax_q, ay_q, sum_q;
   logic [PIX_W-1:0]      res_d;

   always_comb begin
      gx_d = (ext(win_q[0][2]) + (ext(win_q[1][2]) <<< 1) + ext(win_q[2][2]))
           - (ext(win_q[0][0]) + (ext(win_q[1][0]) <<< 1) + ext(win_q[2][0]));
      gy_d = (ext(win_q[2][0]) + (ext(win_q[2][1]) <<< 1) + ext(win_q[2][2]))
           - (ext(win_q[0][0]) + (ext(win_q[0][1]) <<< 1) + ext(win_q[0][2]));
   end

   always_comb begin
      ax_d = gx_q[G_W-1] ? $unsigned(-gx_q) : $unsigned(gx_q);
      ay_d = gy_q[G_W-1] ? $unsigned(-gy_q) : $unsigned(gy_q);
   end

   // Mode and threshold travel with each result so in-flight results of a
   // previous frame keep that frame's settings after a new in_sof.
   logic [1:0]     mode_q, s1_mode_q, s2_mode_q;
   logic [G_W-1:0] thr_q, s1_thr_q, s2_thr_q;

   always_comb begin
      case (s2_mode_q)
         2'd0:    res_d = sat_q4(sum_q);
         2'd1:    res_d = (sum_q >= s2_thr_q) ? PIX_MAX : '0;
         2'd2:    res_d = sat_q4(ax_q);
         default: res_d = sat_q4(ay_q);
      endcase
   end

   // ---------------------------------------------------------------------------
   // Control / valid pipeline (reset) and datapath registers (no reset)
   // ---------------------------------------------------------------------------
   logic             win_vld_q, win_sof_q, win_eof_q;
   logic             s1_vld_q, s1_sof_q, s1_eof_q;
   logic             s2_vld_q, s2_sof_q, s2_eof_q;
   logic             out_valid_q, out_sof_q, out_eof_q;
   logic [PIX_W-1:0] out_pixel_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         col_q       <= '0;
         row_q       <= '0;
         mode_q      <= '0;
         thr_q       <= '0;
         win_vld_q   <= 1'b0;
         win_sof_q   <= 1'b0;
         win_eof_q   <= 1'b0;
         s1_vld_q    <= 1'b0;
         s1_sof_q    <= 1'b0;
         s1_eof_q    <= 1'b0;
         s2_vld_q    <= 1'b0;
         s2_sof_q    <= 1'b0;
         s2_eof_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_pixel_q <= '0;
         out_sof_q   <= 1'b0;
         out_eof_q   <= 1'b0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
         if (accept && in_sof) begin
            mode_q <= mode;
            thr_q  <= threshold;
         end
         // Window centre is (cur_row-1, cur_col-1); it is interior exactly when
         // the accepted pixel is at row >= 2 and col >= 2.
         win_vld_q   <= accept && (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);
         win_sof_q   <= accept && (cur_row == ROW_TWO) && (cur_col == COL_TWO);
         win_eof_q   <= accept && (cur_row == ROW_LAST) && (cur_col == COL_LAST);
         s1_vld_q    <= win_vld_q;
         s1_sof_q    <= win_sof_q;
         s1_eof_q    <= win_eof_q;
         s2_vld_q    <= s1_vld_q;
         s2_sof_q    <= s1_sof_q;
         s2_eof_q    <= s1_eof_q;
         out_valid_q <= s2_vld_q;
         out_pixel_q <= s2_vld_q ? res_d : '0;
         out_sof_q   <= s2_vld_q && s2_sof_q;
         out_eof_q   <= s2_vld_q && s2_eof_q;
      end
   end

   always_ff @(posedge clk) begin
      gx_q      <= gx_d;
      gy_q      <= gy_d;
      s1_mode_q <= mode_q;
      s1_thr_q  <= thr_q;
      ax_q      <= ax_d;
      ay_q      <= ay_d;
      sum_q     <= ax_d + ay_d;
      s2_mode_q <= s1_mode_q;
      s2_thr_q  <= s1_thr_q;
   end

   assign out_valid = out_valid_q;
   assign out_pixel = out_pixel_q;
   assign out_sof   = out_sof_q;
   assign out_eof   = out_eof_q;

endmodule

// File: tb/tb_sobel_stream_filter.sv
// -----------------------------------------------------------------------------
// tb_sobel_stream_filter
// Directed bench for sobel_stream_filter on an 8x6 image. Frames are driven
// pixel by pixel; a monitor records every output with its cycle number and the
// scenario tasks compare the record against hand-derived expected results.
// -----------------------------------------------------------------------------
module tb_sobel_stream_filter;

   localparam int PIX_W = 8;
   localparam int IMG_W = 8;
   localparam int IMG_H = 6;

   logic        clk       = 1'b0;
   logic        rst       = 1'b1;
   logic        in_valid  = 1'b0;
   logic [7:0]  in_pixel  = '0;
   logic        in_sof    = 1'b0;
   logic [1:0]  mode      = '0;
   logic [10:0] threshold = '0;
   logic        out_valid;
   logic [7:0]  out_pixel;
   logic        out_sof;
   logic        out_eof;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   logic [7:0] got_val[$];
   logic       got_sof[$];
   logic       got_eof[$];
   int         got_cyc[$];
   logic [7:0] exp_val[$];
   logic       exp_sof[$];
   logic       exp_eof[$];
   int         exp_cyc[$];

   sobel_stream_filter #(
      .PIX_W (PIX_W),
      .IMG_W (IMG_W),
      .IMG_H (IMG_H)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_pixel  (in_pixel),
      .in_sof    (in_sof),
      .mode      (mode),
      .threshold (threshold),
      .out_valid (out_valid),
      .out_pixel (out_pixel),
      .out_sof   (out_sof),
      .out_eof   (out_eof)
   );

   always #5 clk = ~clk;

   // cyc = number of rising edges so far; stable when read on a falling edge.
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (out_valid === 1'b1) begin
         got_val.push_back(out_pixel);
         got_sof.push_back(out_sof);
         got_eof.push_back(out_eof);
         got_cyc.push_back(cyc);
         $display("out cyc=%0d pix=%0d sof=%0b eof=%0b", cyc, out_pixel, out_sof, out_eof);
      end
   end

   function automatic logic [7:0] pix(input int kind, input int r, input int c);
      case (kind)
         0:       return 8'd100;                                // flat
         1:       return (c >= 4) ? 8'd255 : 8'd0;              // vertical step
         default: return (r >= 3 || c >= 4) ? 8'd255 : 8'd0;    // corner
      endcase
   endfunction

   task automatic idle(input int n);
      in_valid = 1'b0;
      in_sof   = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_q;
      got_val.delete(); got_sof.delete(); got_eof.delete(); got_cyc.delete();
      exp_val.delete(); exp_sof.delete(); exp_eof.delete(); exp_cyc.delete();
   endtask

   task automatic push_exp(input int v, input logic s, input logic e);
      exp_val.push_back(8'(v));
      exp_sof.push_back(s);
      exp_eof.push_back(e);
   endtask

   task automatic push_frame_exp(input int tbl[24]);
      for (int i = 0; i < 24; i++) push_exp(tbl[i], i == 0, i == 23);
   endtask

   // Sends rows 0..nrows-1 of a frame starting with in_sof. After the first
   // pixel, mode/threshold inputs are scrambled: the DUT must keep the values
   // latched at in_sof. Each completing pixel's expected output cycle is the
   // accepting edge + 3.
   task automatic send_frame(input int kind, input logic [1:0] md, input logic [10:0] thr,
                             input int nrows, input int gap);
      for (int r = 0; r < nrows; r++) begin
         for (int c = 0; c < IMG_W; c++) begin
            while (gap > 0 && $urandom_range(0, 99) < gap) begin
               in_valid = 1'b0;
               in_sof   = 1'b0;
               @(negedge clk);
            end
            in_valid = 1'b1;
            in_pixel = pix(kind, r, c);
            in_sof   = (r == 0 && c == 0);
            if (r == 0 && c == 0) begin
               mode      = md;
               threshold = thr;
            end
            if (r >= 2 && c >= 2) exp_cyc.push_back(cyc + 1 + 3);
            @(negedge clk);
            if (r == 0 && c == 0) begin
               mode      = md ^ 2'b01;
               threshold = '0;
            end
         end
      end
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      idle(3);
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b, expected 0", out_valid); end
      n_chk++; if (out_pixel !== 8'd0) begin n_fail++; $display("FAIL reset out_pixel: got %0d, expected 0", out_pixel); end
      n_chk++; if (out_sof !== 1'b0)   begin n_fail++; $display("FAIL reset out_sof: got %b, expected 0", out_sof); end
      n_chk++; if (out_eof !== 1'b0)   begin n_fail++; $display("FAIL reset out_eof: got %b, expected 0", out_eof); end
      rst = 1'b0;
      idle(2);
   endtask

   task automatic test_flat;
      clear_q();
      send_frame(0, 2'd0, 11'd0, IMG_H, 0);
      idle(8);
      for (int i = 0; i < 24; i++) push_exp(0, i == 0, i == 23);
      n_chk++;
      if (got_val.size() != exp_val.size()) begin
         n_fail++; $display("FAIL flat count: got %0d, expected %0d", got_val.size(), exp_val.size());
      end
      for (int i = 0; i < got_val.size() && i < exp_val.size(); i++) begin
         n_chk++;
         if (got_val[i] !== exp_val[i] || got_sof[i] !== exp_sof[i] || got_eof[i] !== exp_eof[i] || got_cyc[i] != exp_cyc[i]) begin
            n_fail++;
            $display("FAIL flat #%0d: got pix=%0d sof=%b eof=%b cyc=%0d, expected pix=%0d sof=%b eof=%b cyc=%0d",
                     i, got_val[i], got_sof[i], got_eof[i], got_cyc[i], exp_val[i], exp_sof[i], exp_eof[i], exp_cyc[i]);
         end
      end
   endtask

   // Step frame: mode 0, mode 1 threshold 1020 (S=1020 at cols 3/4), mode 1
   // threshold 1021 (nothing reaches it).
   task automatic test_step;
      logic [1:0]  md;
      logic [10:0] thr;
      for (int s = 0; s < 3; s++) begin
         md  = (s == 0) ? 2'd0 : 2'd1;
         thr = (s == 2) ? 11'd1021 : ((s == 1) ? 11'd1020 : 11'd0);
         clear_q();
         send_frame(1, md, thr, IMG_H, 0);
         idle(8);
         for (int r = 1; r <= 4; r++)
            for (int c = 1; c <= 6; c++)
               push_exp((s < 2 && (c == 3 || c == 4)) ? 255 : 0, r == 1 && c == 1, r == 4 && c == 6);
         n_chk++;
         if (got_val.size() != exp_val.size()) begin
            n_fail++; $display("FAIL step%0d count: got %0d, expected %0d", s, got_val.size(), exp_val.size());
         end
         for (int i = 0; i < got_val.size() && i < exp_val.size(); i++) begin
            n_chk++;
            if (got_val[i] !== exp_val[i] || got_sof[i] !== exp_sof[i] || got_eof[i] !== exp_eof[i] || got_cyc[i] != exp_cyc[i]) begin
               n_fail++;
               $display("FAIL step%0d #%0d: got pix=%0d sof=%b eof=%b cyc=%0d, expected pix=%0d sof=%b eof=%b cyc=%0d",
                        s, i, got_val[i], got_sof[i], got_eof[i], got_cyc[i], exp_val[i], exp_sof[i], exp_eof[i], exp_cyc[i]);
            end
         end
      end
   endtask

   // Corner frame (255 where row>=3 or col>=4) in modes 0, 2 and 3.
   task automatic test_corner;
      int t0[24];
      int t2[24];
      int t3[24];
      int tbl[24];
      logic [1:0] md;
      t0 = '{0, 0, 255, 255, 0, 0,   255, 255, 255, 255, 0, 0,   255, 255, 255, 127, 0, 0,   0, 0, 0, 0, 0, 0};
      t2 = '{0, 0, 255, 255, 0, 0,   0, 0, 191, 191, 0, 0,       0, 0, 63, 63, 0, 0,         0, 0, 0, 0, 0, 0};
      t3 = '{0, 0, 0, 0, 0, 0,       255, 255, 191, 63, 0, 0,    255, 255, 191, 63, 0, 0,    0, 0, 0, 0, 0, 0};
      for (int s = 0; s < 3; s++) begin
         if (s == 0)      begin md = 2'd0; tbl = t0; end
         else if (s == 1) begin md = 2'd2; tbl = t2; end
         else             begin md = 2'd3; tbl = t3; end
         clear_q();
         send_frame(2, md, 11'd0, IMG_H, 0);
         idle(8);
         push_frame_exp(tbl);
         n_chk++;
         if (got_val.size() != exp_val.size()) begin
            n_fail++; $display("FAIL corner_m%0d count: got %0d, expected %0d", md, got_val.size(), exp_val.size());
         end
         for (int i = 0; i < got_val.size() && i < exp_val.size(); i++) begin
            n_chk++;
            if (got_val[i] !== exp_val[i] || got_sof[i] !== exp_sof[i] || got_eof[i] !== exp_eof[i] || got_cyc[i] != exp_cyc[i]) begin
               n_fail++;
               $display("FAIL corner_m%0d #%0d: got pix=%0d sof=%b eof=%b cyc=%0d, expected pix=%0d sof=%b eof=%b cyc=%0d",
                        md, i, got_val[i], got_sof[i], got_eof[i], got_cyc[i], exp_val[i], exp_sof[i], exp_eof[i], exp_cyc[i]);
            end
         end
      end
   endtask

   // Step frame with ~50% input gaps: same values, each result 3 edges after
   // its completing pixel.
   task automatic test_gaps;
      clear_q();
      send_frame(1, 2'd0, 11'd0, IMG_H, 50);
      idle(8);
      for (int r = 1; r <= 4; r++)
         for (int c = 1; c <= 6; c++)
            push_exp((c == 3 || c == 4) ? 255 : 0, r == 1 && c == 1, r == 4 && c == 6);
      n_chk++;
      if (got_val.size() != exp_val.size()) begin
         n_fail++; $display("FAIL gaps count: got %0d, expected %0d", got_val.size(), exp_val.size());
      end
      for (int i = 0; i < got_val.size() && i < exp_val.size(); i++) begin
         n_chk++;
         if (got_val[i] !== exp_val[i] || got_sof[i] !== exp_sof[i] || got_eof[i] !== exp_eof[i] || got_cyc[i] != exp_cyc[i]) begin
            n_fail++;
            $display("FAIL gaps #%0d: got pix=%0d sof=%b eof=%b cyc=%0d, expected pix=%0d sof=%b eof=%b cyc=%0d",
                     i, got_val[i], got_sof[i], got_eof[i], got_cyc[i], exp_val[i], exp_sof[i], exp_eof[i], exp_cyc[i]);
         end
      end
   endtask

   // Frame A (step) cut off at row 3 by in_sof of flat frame B: A's six row-1
   // results drain, then B gives exactly 24 zeros.
   task automatic test_sof_restart;
      clear_q();
      send_frame(1, 2'd0, 11'd0, 3, 0);
      send_frame(0, 2'd0, 11'd0, IMG_H, 0);
      idle(8);
      for (int c = 1; c <= 6; c++) push_exp((c == 3 || c == 4) ? 255 : 0, c == 1, 1'b0);
      for (int i = 0; i < 24; i++) push_exp(0, i == 0, i == 23);
      n_chk++;
      if (got_val.size() != exp_val.size()) begin
         n_fail++; $display("FAIL sof_restart count: got %0d, expected %0d", got_val.size(), exp_val.size());
      end
      for (int i = 0; i < got_val.size() && i < exp_val.size(); i++) begin
         n_chk++;
         if (got_val[i] !== exp_val[i] || got_sof[i] !== exp_sof[i] || got_eof[i] !== exp_eof[i] || got_cyc[i] != exp_cyc[i]) begin
            n_fail++;
            $display("FAIL sof_restart #%0d: got pix=%0d sof=%b eof=%b cyc=%0d, expected pix=%0d sof=%b eof=%b cyc=%0d",
                     i, got_val[i], got_sof[i], got_eof[i], got_cyc[i], exp_val[i], exp_sof[i], exp_eof[i], exp_cyc[i]);
         end
      end
   endtask

   // Reset right after the last pixel of row 2: results (1,1)..(1,3) have come
   // out (0, 0, 255); (1,4)..(1,6) are still in flight and must be discarded.
   task automatic test_rst_mid;
      int ref_v[3];
      ref_v = '{0, 0, 255};
      clear_q();
      send_frame(1, 2'd0, 11'd0, 3, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid out_valid: got %b, expected 0", out_valid); end
      n_chk++; if (out_pixel !== 8'd0) begin n_fail++; $display("FAIL rst_mid out_pixel: got %0d, expected 0", out_pixel); end
      idle(8);
      n_chk++;
      if (got_val.size() != 3) begin
         n_fail++; $display("FAIL rst_mid count: got %0d, expected 3", got_val.size());
      end
      for (int i = 0; i < got_val.size() && i < 3; i++) begin
         n_chk++;
         if (got_val[i] !== 8'(ref_v[i])) begin
            n_fail++; $display("FAIL rst_mid #%0d: got pix=%0d, expected pix=%0d", i, got_val[i], ref_v[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_flat();
      test_step();
      test_corner();
      test_gaps();
      test_sof_restart();
      test_rst_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
